// File: rtl/bin_window_buffer_b2.sv
// bin_window_buffer_b2
// Buffers 8-channel binary samples from the Block1 pool stage in a small
// circular flop array and presents overlapping KSIZE-sample windows to the
// Block2 PE array over a valid/ready handshake. Windows never span frames:
// after the last window of a frame the frame tail is skipped.
module bin_window_buffer_b2 #(
    parameter int CH        = 8,
    parameter int KSIZE     = 5,
    parameter int FRAME_LEN = 113,
    parameter int DEPTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bin_val,
    input  logic [CH-1:0]         bin_in,
    input  logic                  win_ready,
    output logic                  win_val,
    output logic [KSIZE*CH-1:0]   win_data,
    output logic [6:0]            win_idx,
    output logic                  win_last,
    output logic                  frame_done,
    output logic                  overflow
);

    localparam int NWIN = FRAME_LEN - KSIZE + 1;
    localparam int PW   = $clog2(DEPTH);
    localparam int WW   = KSIZE * CH;

    typedef enum logic [0:0] {
        ST_FILL    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    logic [CH-1:0] mem_q [DEPTH];
    logic [CH-1:0] mem_d [DEPTH];
    logic [PW:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]   rd_ptr_q, rd_ptr_d;
    logic [6:0]    win_cnt_q, win_cnt_d;
    state_t        state_q, state_d;
    logic          win_val_q, win_val_d;
    logic [WW-1:0] win_data_q, win_data_d;
    logic [6:0]    win_idx_q, win_idx_d;
    logic          win_last_q, win_last_d;
    logic          frame_done_q, frame_done_d;
    logic          overflow_q, overflow_d;

    logic [PW:0]   occ_s;
    logic [PW+1:0] avail_s;
    logic          full_s;
    logic          wr_en_s;
    logic          hs_s;
    logic [PW-1:0] base_s;
    logic [PW-1:0] slot_s;
    logic [WW-1:0] gather_s;

    // Occupancy from the wrap-bit pointers; a sample is stored only when not full.
    assign occ_s   = wr_ptr_q - rd_ptr_q;
    assign full_s  = (occ_s == (PW+1)'(DEPTH));
    assign wr_en_s = bin_val & ~full_s;
    assign hs_s    = win_val_q & win_ready;
    // Entries left after a pop, counting a sample written in the same cycle.
    assign avail_s = {1'b0, occ_s} - (PW+2)'(1) + {{(PW+1){1'b0}}, wr_en_s};
    // Oldest sample of the window being loaded: current head in FILL, next head on a pop.
    assign base_s  = (state_q == ST_PRESENT) ? (rd_ptr_q[PW-1:0] + PW'(1)) : rd_ptr_q[PW-1:0];

    // Gather KSIZE samples starting at base_s, bypassing a same-cycle write.
    always_comb begin
        gather_s = {WW{1'b0}};
        slot_s   = {PW{1'b0}};
        for (int i = 0; i < KSIZE; i++) begin
            slot_s = base_s + PW'(i);
            if (wr_en_s && (slot_s == wr_ptr_q[PW-1:0])) begin
                gather_s[i*CH +: CH] = bin_in;
            end else begin
                gather_s[i*CH +: CH] = mem_q[slot_s];
            end
        end
    end

    // Next-state logic: buffer write, overflow flag and FILL/PRESENT window control.
    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        win_cnt_d    = win_cnt_q;
        state_d      = state_q;
        win_val_d    = win_val_q;
        win_data_d   = win_data_q;
        win_idx_d    = win_idx_q;
        win_last_d   = win_last_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;

        if (wr_en_s) begin
            mem_d[wr_ptr_q[PW-1:0]] = bin_in;
            wr_ptr_d                = wr_ptr_q + (PW+1)'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (bin_val && full_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end

        case (state_q)
            ST_FILL: begin
                if (occ_s >= (PW+1)'(KSIZE)) begin
                    win_data_d = gather_s;
                    win_idx_d  = win_cnt_q;
                    win_last_d = (win_cnt_q == 7'(NWIN - 1));
                    win_val_d  = 1'b1;
                    state_d    = ST_PRESENT;
                end else begin
                    win_val_d = 1'b0;
                    state_d   = ST_FILL;
                end
            end
            ST_PRESENT: begin
                if (hs_s) begin
                    if (win_last_q) begin
                        // Skip the frame tail so the next window starts on a new frame.
                        rd_ptr_d     = rd_ptr_q + (PW+1)'(KSIZE);
                        win_cnt_d    = 7'd0;
                        frame_done_d = 1'b1;
                        win_val_d    = 1'b0;
                        win_last_d   = 1'b0;
                        state_d      = ST_FILL;
                    end else begin
                        rd_ptr_d  = rd_ptr_q + (PW+1)'(1);
                        win_cnt_d = win_cnt_q + 7'd1;
                        if (avail_s >= (PW+2)'(KSIZE)) begin
                            win_data_d = gather_s;
                            win_idx_d  = win_cnt_q + 7'd1;
                            win_last_d = ((win_cnt_q + 7'd1) == 7'(NWIN - 1));
                            win_val_d  = 1'b1;
                            state_d    = ST_PRESENT;
                        end else begin
                            win_val_d = 1'b0;
                            state_d   = ST_FILL;
                        end
                    end
                end else begin
                    win_val_d = 1'b1;
                    state_d   = ST_PRESENT;
                end
            end
            default: begin
                win_val_d = 1'b0;
                state_d   = ST_FILL;
            end
        endcase
    end

    // State and output registers; reset discards buffered data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {CH{1'b0}};
            end
            wr_ptr_q     <= {(PW+1){1'b0}};
            rd_ptr_q     <= {(PW+1){1'b0}};
            win_cnt_q    <= 7'd0;
            state_q      <= ST_FILL;
            win_val_q    <= 1'b0;
            win_data_q   <= {WW{1'b0}};
            win_idx_q    <= 7'd0;
            win_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            win_cnt_q    <= win_cnt_d;
            state_q      <= state_d;
            win_val_q    <= win_val_d;
            win_data_q   <= win_data_d;
            win_idx_q    <= win_idx_d;
            win_last_q   <= win_last_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign win_val    = win_val_q;
    assign win_data   = win_data_q;
    assign win_idx    = win_idx_q;
    assign win_last   = win_last_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_bin_window_buffer_b2.sv
// Directed bench for bin_window_buffer_b2: reset, streaming, backpressure,
// overflow, sparse frame chaining and mid-frame reset. A negedge monitor
// checks every accepted window against the expected sample sequence.
module tb_bin_window_buffer_b2;

    localparam int CH    = 8;
    localparam int KSIZE = 5;
    localparam int FLEN  = 113;
    localparam int NWIN  = FLEN - KSIZE + 1;

    logic                clk;
    logic                rst_n;
    logic                bin_val;
    logic [CH-1:0]       bin_in;
    logic                win_ready;
    logic                win_val;
    logic [KSIZE*CH-1:0] win_data;
    logic [6:0]          win_idx;
    logic                win_last;
    logic                frame_done;
    logic                overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the window sequence.
    bit mon_en      = 1'b0;
    int exp_k       = 0;
    int frame_base  = 0;
    bit fd_exp      = 1'b0;
    int win_seen    = 0;
    int frames_done = 0;
    int cyc         = 0;
    int t_first     = 0;
    int t_last      = 0;

    bin_window_buffer_b2 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bin_val    (bin_val),
        .bin_in     (bin_in),
        .win_ready  (win_ready),
        .win_val    (win_val),
        .win_data   (win_data),
        .win_idx    (win_idx),
        .win_last   (win_last),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected window whose oldest sample has index 'first' (data = index[7:0]).
    function automatic logic [KSIZE*CH-1:0] win_of(input int first);
        logic [KSIZE*CH-1:0] w;
        w = '0;
        for (int i = 0; i < KSIZE; i++) w[i*CH +: CH] = 8'(first + i);
        return w;
    endfunction

    task automatic reset_model();
        exp_k       = 0;
        frame_base  = 0;
        fd_exp      = 1'b0;
        win_seen    = 0;
        frames_done = 0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        bin_val   = 1'b0;
        bin_in    = 8'd0;
        win_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_model();
    endtask

    // n samples, one every 'period' clocks, then 'tail' idle clocks.
    task automatic stream(input int n, input int period, input int tail);
        for (int s = 0; s < n; s++) begin
            for (int p = 0; p < period; p++) begin
                bin_val = (p == 0);
                bin_in  = 8'(s);
                @(posedge clk);
                #1;
            end
        end
        bin_val = 1'b0;
        repeat (tail) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Window monitor: checks each handshake and the frame_done pulse that follows the last one.
    always @(negedge clk) begin
        if (mon_en) begin
            check_val("frame_done", frame_done, fd_exp);
            fd_exp = 1'b0;
            if (win_val && win_ready) begin
                check_val("win_idx", win_idx, exp_k);
                check_val("win_data", win_data, win_of(frame_base + exp_k));
                check_val("win_last", win_last, (exp_k == NWIN - 1));
                if (exp_k == 0) t_first = cyc;
                win_seen++;
                if (exp_k == NWIN - 1) begin
                    t_last = cyc;
                    fd_exp = 1'b1;
                    exp_k  = 0;
                    frame_base += FLEN;
                    frames_done++;
                end else begin
                    exp_k++;
                end
            end
        end
    end

    initial begin
        int  stall_left;
        bit  bp_done;
        bit  found;

        rst_n     = 1'b0;
        bin_val   = 1'b0;
        bin_in    = 8'd0;
        win_ready = 1'b1;

        // Reset with bin_val toggling: outputs stay at zero.
        for (int t = 0; t < 6; t++) begin
            bin_val = t[0];
            bin_in  = 8'(t);
            @(posedge clk);
            #1;
        end
        check_val("rst_win_val", win_val, 1'b0);
        check_val("rst_win_data", win_data, 40'd0);
        check_val("rst_win_idx", win_idx, 7'd0);
        check_val("rst_win_last", win_last, 1'b0);
        check_val("rst_frame_done", frame_done, 1'b0);
        check_val("rst_overflow", overflow, 1'b0);
        rst_n   = 1'b1;
        bin_val = 1'b0;
        reset_model();

        // Streaming frame with latency check.
        mon_en    = 1'b1;
        win_ready = 1'b1;
        for (int t = 0; t < FLEN; t++) begin
            bin_val = 1'b1;
            bin_in  = 8'(t);
            @(posedge clk);
            #1;
            if (t == 3 || t == 4) check_val("win_val_early", win_val, 1'b0);
            if (t == 5) begin
                check_val("win_val_rise", win_val, 1'b1);
                check_val("win0_data", win_data, win_of(0));
            end
        end
        bin_val = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        check_val("stream_windows", win_seen, NWIN);
        check_val("stream_frames", frames_done, 1);
        check_val("stream_back2back", t_last - t_first, NWIN - 1);
        check_val("stream_overflow", overflow, 1'b0);
        check_val("stream_idle_val", win_val, 1'b0);

        // Backpressure: stall 8 clocks on window 10.
        do_reset();
        mon_en     = 1'b1;
        stall_left = 0;
        bp_done    = 1'b0;
        for (int t = 0; t < FLEN + 30; t++) begin
            bin_val = (t < FLEN);
            bin_in  = 8'(t);
            if (stall_left > 0) begin
                check_val("bp_idx", win_idx, 7'd10);
                check_val("bp_data", win_data, win_of(10));
                check_val("bp_val", win_val, 1'b1);
                win_ready = 1'b0;
                stall_left--;
            end else if (!bp_done && win_val && win_idx == 7'd10) begin
                check_val("bp_data", win_data, win_of(10));
                win_ready  = 1'b0;
                bp_done    = 1'b1;
                stall_left = 7;
            end else begin
                win_ready = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        check_val("bp_stalled", bp_done, 1'b1);
        check_val("bp_windows", win_seen, NWIN);
        check_val("bp_frames", frames_done, 1);
        check_val("bp_overflow", overflow, 1'b0);

        // Overflow: 17 samples with no draining.
        mon_en = 1'b0;
        do_reset();
        check_val("ovf_after_reset", overflow, 1'b0);
        win_ready = 1'b0;
        for (int t = 0; t < 17; t++) begin
            bin_val = 1'b1;
            bin_in  = 8'(t);
            @(posedge clk);
            #1;
            if (t == 15) check_val("ovf_not_yet", overflow, 1'b0);
            if (t == 16) check_val("ovf_rise", overflow, 1'b1);
        end
        bin_val = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check_val("ovf_sticky", overflow, 1'b1);
        check_val("ovf_win_val", win_val, 1'b1);
        check_val("ovf_win_idx", win_idx, 7'd0);
        check_val("ovf_win_data", win_data, win_of(0));

        // Sparse input across two frames.
        do_reset();
        mon_en    = 1'b1;
        win_ready = 1'b1;
        stream(2 * FLEN, 3, 20);
        check_val("sparse_frames", frames_done, 2);
        check_val("sparse_windows", win_seen, 2 * NWIN);
        check_val("sparse_overflow", overflow, 1'b0);

        // Mid-frame reset at window 50, then restart.
        do_reset();
        mon_en    = 1'b1;
        win_ready = 1'b1;
        found     = 1'b0;
        for (int t = 0; t < FLEN && !found; t++) begin
            bin_val = 1'b1;
            bin_in  = 8'(t);
            @(posedge clk);
            #1;
            if (win_val && win_idx == 7'd50) found = 1'b1;
        end
        check_val("mid_reached_50", found, 1'b1);
        rst_n   = 1'b0;
        bin_val = 1'b0;
        #1;
        check_val("mid_rst_val", win_val, 1'b0);
        check_val("mid_rst_idx", win_idx, 7'd0);
        check_val("mid_rst_data", win_data, 40'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_model();
        stream(6, 1, 0);
        check_val("mid_first_idx", win_idx, 7'd0);
        check_val("mid_first_data", win_data, win_of(0));
        check_val("mid_first_val", win_val, 1'b1);
        mon_en = 1'b0;
        do_reset();
        mon_en    = 1'b1;
        win_ready = 1'b1;
        stream(FLEN, 1, 12);
        check_val("mid_windows", win_seen, NWIN);
        check_val("mid_frames", frames_done, 1);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bin_window_buffer_b2.md
# bin_window_buffer_b2

Stage directly downstream of the Block1 max-pool/threshold output. Accepts one 8-channel binary sample per `bin_val` pulse (`Bin_0`..`Bin_7` packed), holds samples in a small circular flop buffer, and presents overlapping KSIZE-sample windows with a valid/ready handshake to the Block2 XNOR-popcount PE array. Frames are FRAME_LEN samples long; windows never straddle a frame boundary.

## Interface
- CH, 8: channels per sample (width of `bin_in`)
- KSIZE, 5: window length in samples
- FRAME_LEN, 113: samples per frame (Block1 pooled length)
- DEPTH, 16: buffer entries, power of two, >= KSIZE+1
- NWIN (localparam), FRAME_LEN-KSIZE+1 = 109: windows per frame

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- bin_val  in  1  upstream sample strobe (no backpressure to upstream)
- bin_in  in  CH  sample; bit c = channel c (`Bin_c`)
- win_ready  in  1  downstream accepts current window
- win_val  out  1  window valid
- win_data  out  KSIZE*CH  window; `win_data[i*CH +: CH]` = sample base+i, i=0 oldest
- win_idx  out  7  window index within frame, 0..NWIN-1
- win_last  out  1  high with win_val on window NWIN-1
- frame_done  out  1  one-cycle pulse after last window handshake
- overflow  out  1  sticky: a sample was dropped because the buffer was full

## Operation
- Storage: DEPTH x CH flop array, wr_ptr/rd_ptr of log2(DEPTH)+1 bits (wrap bit); occupancy = wr_ptr - rd_ptr (mod 2*DEPTH); full = occupancy==DEPTH.
- Write: `bin_val` && !full -> mem[wr_ptr] <= bin_in, wr_ptr++. `bin_val` && full -> sample dropped, overflow <= 1 (cleared only by reset).
- States: FILL, PRESENT.
  - FILL: win_val=0. If occupancy >= KSIZE (evaluated on registered pointers), load win_data from mem[rd_ptr..rd_ptr+KSIZE-1], win_idx <= win_cnt, win_last <= (win_cnt==NWIN-1), go PRESENT.
  - PRESENT: win_val=1; win_data/win_idx/win_last held stable until handshake. On win_val && win_ready:
    - not last: rd_ptr += 1, win_cnt++; if occupancy-1 >= KSIZE (counting a same-cycle write) reload next window and stay PRESENT (back-to-back, one window per cycle); else FILL.
    - last: rd_ptr += KSIZE (discards frame tail), win_cnt <= 0, frame_done pulses next cycle, go FILL.
- Simultaneous write and pop: both take effect; occupancy unchanged by net.
- Samples of the next frame may arrive before the current frame's last handshake; they are buffered normally and belong to the next frame.
- Reset mid-operation: pointers, win_cnt, all outputs return to reset values; buffered data discarded.

## Timing
- Reset values: win_val=0, win_data=0, win_idx=0, win_last=0, frame_done=0, overflow=0; state FILL.
- Latency: window first presentable in the cycle after the write of its KSIZE-th sample (win_val rises 1 clk after that `bin_val`).
- Throughput: 1 window/clk when input keeps up and win_ready=1.
- frame_done: high exactly the cycle after the last-window handshake, independent of win_ready.
- overflow: rises the cycle after the dropping `bin_val`.

## Test plan
- Reset: hold rst_n=0 with bin_val toggling -> all outputs 0; release -> win_val stays 0 until 5 samples written.
- Streaming frame: bin_val=1 every clk, bin_in=sample index[7:0], win_ready=1 -> win_val rises 1 clk after sample 4; window 0 data {4,3,2,1,0} (slot 0 = 0); 109 windows in consecutive cycles; window 108 = samples 108..112 with win_last=1; frame_done one cycle later; overflow=0.
- Backpressure: stream as above, win_ready=0 for 8 clks at window 10 -> win_data/win_idx=10 stable all 8 clks; after release windows 10,11,… resume with no gap or loss; overflow=0.
- Overflow: win_ready=0, 17 consecutive samples -> first 16 stored, 17th dropped, overflow=1 next clk and stays 1; window 0 still {4,3,2,1,0}.
- Sparse input / frame chaining: bin_val every 3rd clk for 2×113 samples, win_ready=1 -> 109 windows per frame; frame 2 window 0 = samples 113..117; no window mixes frames.
- Mid-frame reset: assert rst_n=0 at window 50 for 2 clks, then restart stream from index 0 -> first window after restart is win_idx=0, data {4,3,2,1,0}.
